// File: rtl/mano_bus_datapath_if.sv
// Common-bus interface between the Mano control unit/memory side and the
// receiving datapath: bus select, register controls, memory port and register views.
interface mano_bus_datapath_if;
  logic [2:0]  s;
  logic        ld_ar, inr_ar, clr_ar;
  logic        ld_pc, inr_pc, clr_pc;
  logic        ld_dr, inr_dr, clr_dr;
  logic        ld_ac, inr_ac, clr_ac;
  logic        ld_ir;
  logic        ld_tr, inr_tr, clr_tr;
  logic        sc_inr, sc_clr;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] bus;
  logic [11:0] ar, pc;
  logic [15:0] dr, ac, ir, tr;
  logic [3:0]  sc;
  logic        err;

  modport master (
    output s, ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc, ld_dr, inr_dr, clr_dr,
           ld_ac, inr_ac, clr_ac, ld_ir, ld_tr, inr_tr, clr_tr, sc_inr, sc_clr,
           mem_wr, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, bus, ar, pc, dr, ac, ir, tr, sc, err
  );

  modport slave (
    input  s, ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc, ld_dr, inr_dr, clr_dr,
           ld_ac, inr_ac, clr_ac, ld_ir, ld_tr, inr_tr, clr_tr, sc_inr, sc_clr,
           mem_wr, mem_rdata,
    output mem_addr, mem_wdata, mem_we, bus, ar, pc, dr, ac, ir, tr, sc, err
  );
endinterface

// File: rtl/mano_bus_datapath.sv
// Mano basic-computer common bus: source mux, destination registers, sequence
// counter, memory write port and a sticky illegal-operation flag.
module mano_bus_datapath (
  input logic               clk,
  input logic               rst_n,
  mano_bus_datapath_if.slave bif
);

  logic [11:0] ar_r, pc_r;
  logic [15:0] dr_r, ac_r, ir_r, tr_r;
  logic [3:0]  sc_r;
  logic        err_r;
  logic [15:0] bus_s;
  logic        illegal_s;

  // Per-register update with clr > ld > inr priority; increment wraps naturally.
  function automatic logic [15:0] next16(input logic [15:0] cur, input logic clr,
                                         input logic ld, input logic inr,
                                         input logic [15:0] busv);
    logic [15:0] nxt;
    if (clr)      nxt = 16'h0000;
    else if (ld)  nxt = busv;
    else if (inr) nxt = cur + 16'h0001;
    else          nxt = cur;
    return nxt;
  endfunction

  function automatic logic [11:0] next12(input logic [11:0] cur, input logic clr,
                                         input logic ld, input logic inr,
                                         input logic [11:0] busv);
    logic [11:0] nxt;
    if (clr)      nxt = 12'h000;
    else if (ld)  nxt = busv;
    else if (inr) nxt = cur + 12'h001;
    else          nxt = cur;
    return nxt;
  endfunction

  // Bus source selection.
  always_comb begin
    bus_s = 16'h0000;
    case (bif.s)
      3'd1:    bus_s = {4'h0, ar_r};
      3'd2:    bus_s = {4'h0, pc_r};
      3'd3:    bus_s = dr_r;
      3'd4:    bus_s = ac_r;
      3'd5:    bus_s = ir_r;
      3'd6:    bus_s = tr_r;
      3'd7:    bus_s = bif.mem_rdata;
      default: bus_s = 16'h0000;
    endcase
  end

  // Memory-to-memory transfer and ambiguous AR/PC load+increment are flagged.
  assign illegal_s = (bif.mem_wr & (bif.s == 3'd7)) |
                     (bif.ld_ar & bif.inr_ar) |
                     (bif.ld_pc & bif.inr_pc);

  // Register, sequence-counter and error-flag state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_r  <= 12'h000;
      pc_r  <= 12'h000;
      dr_r  <= 16'h0000;
      ac_r  <= 16'h0000;
      ir_r  <= 16'h0000;
      tr_r  <= 16'h0000;
      sc_r  <= 4'h0;
      err_r <= 1'b0;
    end else begin
      ar_r  <= next12(ar_r, bif.clr_ar, bif.ld_ar, bif.inr_ar, bus_s[11:0]);
      pc_r  <= next12(pc_r, bif.clr_pc, bif.ld_pc, bif.inr_pc, bus_s[11:0]);
      dr_r  <= next16(dr_r, bif.clr_dr, bif.ld_dr, bif.inr_dr, bus_s);
      ac_r  <= next16(ac_r, bif.clr_ac, bif.ld_ac, bif.inr_ac, bus_s);
      ir_r  <= next16(ir_r, 1'b0, bif.ld_ir, 1'b0, bus_s);
      tr_r  <= next16(tr_r, bif.clr_tr, bif.ld_tr, bif.inr_tr, bus_s);
      if (bif.sc_clr)      sc_r <= 4'h0;
      else if (bif.sc_inr) sc_r <= sc_r + 4'h1;
      else                 sc_r <= sc_r;
      err_r <= err_r | illegal_s;
    end
  end

  // Address uses the pre-edge AR, so a same-cycle AR update cannot redirect a write.
  assign bif.mem_addr  = ar_r;
  assign bif.mem_wdata = bus_s;
  assign bif.mem_we    = bif.mem_wr & (bif.s != 3'd7);
  assign bif.bus       = bus_s;
  assign bif.ar        = ar_r;
  assign bif.pc        = pc_r;
  assign bif.dr        = dr_r;
  assign bif.ac        = ac_r;
  assign bif.ir        = ir_r;
  assign bif.tr        = tr_r;
  assign bif.sc        = sc_r;
  assign bif.err       = err_r;

endmodule

// File: tb/tb_mano_bus_datapath.sv
// Self-checking bench for mano_bus_datapath: directed scenarios plus randomized
// traffic compared against an arithmetic model of the register-transfer rules.
module tb_mano_bus_datapath;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [15:0] mem [4096];

  logic [11:0] m_ar, m_pc;
  logic [15:0] m_dr, m_ac, m_ir, m_tr;
  logic [3:0]  m_sc;
  logic        m_err;

  mano_bus_datapath_if bif ();

  mano_bus_datapath dut (.clk(clk), .rst_n(rst_n), .bif(bif));

  assign bif.mem_rdata = mem[bif.mem_addr];

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_bus(input logic [2:0] sel);
    logic [15:0] src [8];
    src[0] = 16'h0000;
    src[1] = {4'h0, m_ar};
    src[2] = {4'h0, m_pc};
    src[3] = m_dr;
    src[4] = m_ac;
    src[5] = m_ir;
    src[6] = m_tr;
    src[7] = mem[m_ar];
    return src[sel];
  endfunction

  function automatic logic [15:0] upd(input logic [15:0] cur, input int modulus,
                                      input logic clr, input logic ld, input logic inr,
                                      input logic [15:0] b);
    int v;
    if (clr)      v = 0;
    else if (ld)  v = int'(b) % modulus;
    else if (inr) v = (int'(cur) + 1) % modulus;
    else          v = int'(cur);
    return 16'(v);
  endfunction

  task automatic idle();
    bif.s = 3'd0;
    {bif.ld_ar, bif.inr_ar, bif.clr_ar, bif.ld_pc, bif.inr_pc, bif.clr_pc} = 6'b0;
    {bif.ld_dr, bif.inr_dr, bif.clr_dr, bif.ld_ac, bif.inr_ac, bif.clr_ac} = 6'b0;
    {bif.ld_ir, bif.ld_tr, bif.inr_tr, bif.clr_tr} = 4'b0;
    {bif.sc_inr, bif.sc_clr, bif.mem_wr} = 3'b0;
  endtask

  // One clock edge: advance the model, let the environment memory honour the DUT write.
  task automatic tick();
    logic [15:0] b, d_wdata;
    logic [11:0] d_addr;
    logic        d_we;
    logic [11:0] n_ar, n_pc;
    logic [15:0] n_dr, n_ac, n_ir, n_tr;
    logic [3:0]  n_sc;
    logic        n_err;
    b = exp_bus(bif.s);
    d_we = bif.mem_we; d_addr = bif.mem_addr; d_wdata = bif.mem_wdata;
    if (!rst_n) begin
      {n_ar, n_pc} = 24'h0;
      {n_dr, n_ac, n_ir, n_tr} = 64'h0;
      n_sc = 4'h0; n_err = 1'b0;
    end else begin
      n_ar = 12'(upd({4'h0, m_ar}, 4096, bif.clr_ar, bif.ld_ar, bif.inr_ar, b));
      n_pc = 12'(upd({4'h0, m_pc}, 4096, bif.clr_pc, bif.ld_pc, bif.inr_pc, b));
      n_dr = upd(m_dr, 65536, bif.clr_dr, bif.ld_dr, bif.inr_dr, b);
      n_ac = upd(m_ac, 65536, bif.clr_ac, bif.ld_ac, bif.inr_ac, b);
      n_ir = upd(m_ir, 65536, 1'b0, bif.ld_ir, 1'b0, b);
      n_tr = upd(m_tr, 65536, bif.clr_tr, bif.ld_tr, bif.inr_tr, b);
      n_sc = bif.sc_clr ? 4'h0 : (bif.sc_inr ? 4'((int'(m_sc) + 1) % 16) : m_sc);
      n_err = m_err || (bif.mem_wr && bif.s == 3'd7) || (bif.ld_ar && bif.inr_ar) ||
              (bif.ld_pc && bif.inr_pc);
    end
    @(posedge clk);
    if (d_we) mem[d_addr] = d_wdata;
    m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir; m_tr = n_tr;
    m_sc = n_sc; m_err = n_err;
    #1;
  endtask

  task automatic load_via_mem(input logic [15:0] v, input logic [2:0] which);
    idle();
    mem[m_ar] = v;
    bif.s = 3'd7;
    case (which)
      3'd1: bif.ld_ar = 1'b1;
      3'd2: bif.ld_pc = 1'b1;
      3'd3: bif.ld_dr = 1'b1;
      3'd4: bif.ld_ac = 1'b1;
      default: bif.ld_tr = 1'b1;
    endcase
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.s = 3'($urandom_range(0, 6));
      {bif.ld_ar, bif.inr_ar, bif.clr_ar, bif.ld_pc, bif.inr_pc, bif.clr_pc} = 6'($urandom);
      {bif.ld_ac, bif.inr_ac, bif.sc_inr, bif.ld_ir} = 4'($urandom);
      bif.mem_wr = 1'b0;
      tick();
    end
    idle();
    #1;
    n_checks++;
    if ({bif.ar, bif.pc, bif.dr, bif.ac, bif.ir, bif.tr, bif.sc, bif.err} !== 93'h0) begin
      n_fail++; $display("FAIL reset_regs: ar=%h pc=%h dr=%h ac=%h ir=%h tr=%h sc=%h err=%b required all 0",
                         bif.ar, bif.pc, bif.dr, bif.ac, bif.ir, bif.tr, bif.sc, bif.err);
    end
    n_checks++;
    if (bif.bus !== 16'h0000) begin n_fail++; $display("FAIL reset_bus: got %h required 0000", bif.bus); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    load_via_mem(16'h0010, 3'd2);
    mem[12'h010] = 16'h7800;
    bif.sc_clr = 1'b1; tick(); idle();
    bif.s = 3'd2; bif.ld_ar = 1'b1; bif.sc_inr = 1'b1; tick(); idle();
    n_checks++;
    if ({bif.ar, bif.sc} !== {12'h010, 4'h1}) begin
      n_fail++; $display("FAIL fetch_t0: ar=%h sc=%h required ar=010 sc=1", bif.ar, bif.sc);
    end
    bif.s = 3'd7; bif.ld_ir = 1'b1; bif.inr_pc = 1'b1; bif.sc_inr = 1'b1; #1;
    n_checks++;
    if (bif.bus !== 16'h7800) begin n_fail++; $display("FAIL fetch_bus: got %h required 7800", bif.bus); end
    tick(); idle();
    n_checks++;
    if ({bif.ir, bif.pc, bif.sc} !== {16'h7800, 12'h011, 4'h2}) begin
      n_fail++; $display("FAIL fetch_t1: ir=%h pc=%h sc=%h required ir=7800 pc=011 sc=2", bif.ir, bif.pc, bif.sc);
    end
    bif.s = 3'd5; bif.ld_ar = 1'b1; bif.sc_inr = 1'b1; tick(); idle();
    n_checks++;
    if ({bif.ar, bif.sc} !== {12'h800, 4'h3}) begin
      n_fail++; $display("FAIL fetch_t2: ar=%h sc=%h required ar=800 sc=3", bif.ar, bif.sc);
    end
  endtask

  task automatic test_wrap_priority();
    load_via_mem(16'hFFFF, 3'd4);
    bif.inr_ac = 1'b1; tick(); idle();
    n_checks++;
    if (bif.ac !== 16'h0000) begin n_fail++; $display("FAIL ac_wrap: got %h required 0000", bif.ac); end
    load_via_mem(16'h0FFF, 3'd2);
    bif.inr_pc = 1'b1; tick(); idle();
    n_checks++;
    if (bif.pc !== 12'h000) begin n_fail++; $display("FAIL pc_wrap: got %h required 000", bif.pc); end
    load_via_mem(16'h5A5A, 3'd4);
    mem[m_ar] = 16'h1234;
    bif.s = 3'd7; bif.clr_ac = 1'b1; bif.ld_ac = 1'b1; bif.inr_ac = 1'b1; tick(); idle();
    n_checks++;
    if (bif.ac !== 16'h0000) begin n_fail++; $display("FAIL ac_priority: got %h required 0000", bif.ac); end
    bif.sc_clr = 1'b1; tick(); idle();
    bif.sc_inr = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (bif.sc !== 4'hF) begin n_fail++; $display("FAIL sc_count: got %h required f", bif.sc); end
    tick(); idle();
    n_checks++;
    if (bif.sc !== 4'h0) begin n_fail++; $display("FAIL sc_wrap: got %h required 0", bif.sc); end
  endtask

  task automatic test_mem_write();
    load_via_mem(16'h0123, 3'd1);
    load_via_mem(16'hBEEF, 3'd4);
    mem[12'h123] = 16'h0000;
    bif.s = 3'd4; bif.mem_wr = 1'b1; #1;
    n_checks++;
    if ({bif.mem_we, bif.mem_addr, bif.mem_wdata} !== {1'b1, 12'h123, 16'hBEEF}) begin
      n_fail++; $display("FAIL mem_write_port: we=%b addr=%h wdata=%h required we=1 addr=123 wdata=beef",
                         bif.mem_we, bif.mem_addr, bif.mem_wdata);
    end
    bif.ld_ar = 1'b1;
    tick(); idle();
    n_checks++;
    if ({mem[12'h123], bif.ar, bif.err} !== {16'hBEEF, 12'hEEF, 1'b0}) begin
      n_fail++; $display("FAIL mem_write_old_ar: m[123]=%h ar=%h err=%b required beef eef 0",
                         mem[12'h123], bif.ar, bif.err);
    end
  endtask

  task automatic test_illegal();
    bif.s = 3'd7; bif.mem_wr = 1'b1; #1;
    n_checks++;
    if (bif.mem_we !== 1'b0) begin n_fail++; $display("FAIL m2m_we: got %b required 0", bif.mem_we); end
    tick(); idle();
    n_checks++;
    if (bif.err !== 1'b1) begin n_fail++; $display("FAIL m2m_err_set: got %b required 1", bif.err); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bif.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", bif.err); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_checks++;
    if (bif.err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b required 0", bif.err); end
    mem[12'h000] = 16'h0456;
    bif.s = 3'd7; bif.ld_ar = 1'b1; bif.inr_ar = 1'b1; tick(); idle();
    n_checks++;
    if ({bif.ar, bif.err} !== {12'h456, 1'b1}) begin
      n_fail++; $display("FAIL ar_ld_inr: ar=%h err=%b required ar=456 err=1", bif.ar, bif.err);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bif.s = 3'd7; bif.ld_pc = 1'b1; bif.inr_pc = 1'b1; tick(); idle();
    n_checks++;
    if ({bif.pc, bif.err} !== {mem[12'h000][11:0], 1'b1}) begin
      n_fail++; $display("FAIL pc_ld_inr: pc=%h err=%b required pc=456 err=1", bif.pc, bif.err);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    load_via_mem(16'h00AA, 3'd3);
    load_via_mem(16'h5555, 3'd4);
    bif.sc_clr = 1'b1; tick(); idle();
    bif.sc_inr = 1'b1; tick(); tick(); idle();
    bif.s = 3'd3; bif.ld_ac = 1'b1; bif.sc_inr = 1'b1; rst_n = 1'b0;
    tick(); idle(); rst_n = 1'b1;
    n_checks++;
    if ({bif.ac, bif.sc} !== {16'h0000, 4'h0}) begin
      n_fail++; $display("FAIL reset_mid: ac=%h sc=%h required ac=0000 sc=0", bif.ac, bif.sc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bif.s = 3'($urandom_range(0, 7));
      bif.ld_ar = ($urandom_range(0, 3) == 0); bif.inr_ar = ($urandom_range(0, 3) == 0);
      bif.clr_ar = ($urandom_range(0, 9) == 0);
      bif.ld_pc = ($urandom_range(0, 3) == 0); bif.inr_pc = ($urandom_range(0, 3) == 0);
      bif.clr_pc = ($urandom_range(0, 9) == 0);
      bif.ld_dr = ($urandom_range(0, 3) == 0); bif.inr_dr = ($urandom_range(0, 3) == 0);
      bif.clr_dr = ($urandom_range(0, 9) == 0);
      bif.ld_ac = ($urandom_range(0, 3) == 0); bif.inr_ac = ($urandom_range(0, 3) == 0);
      bif.clr_ac = ($urandom_range(0, 9) == 0);
      bif.ld_ir = ($urandom_range(0, 3) == 0);
      bif.ld_tr = ($urandom_range(0, 3) == 0); bif.inr_tr = ($urandom_range(0, 3) == 0);
      bif.clr_tr = ($urandom_range(0, 9) == 0);
      bif.sc_inr = ($urandom_range(0, 1) == 0); bif.sc_clr = ($urandom_range(0, 9) == 0);
      bif.mem_wr = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      n_checks++;
      if ({bif.bus, bif.mem_we, bif.mem_addr, bif.mem_wdata} !==
          {exp_bus(bif.s), bif.mem_wr && bif.s != 3'd7, m_ar, exp_bus(bif.s)}) begin
        n_fail++; $display("FAIL rand_comb[%0d]: bus=%h we=%b addr=%h required bus=%h addr=%h", i,
                           bif.bus, bif.mem_we, bif.mem_addr, exp_bus(bif.s), m_ar);
      end
      tick();
      n_checks++;
      if ({bif.ar, bif.pc, bif.dr, bif.ac, bif.ir, bif.tr, bif.sc, bif.err} !==
          {m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_sc, m_err}) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got %h %h %h %h %h %h %h %b required %h %h %h %h %h %h %h %b", i,
                           bif.ar, bif.pc, bif.dr, bif.ac, bif.ir, bif.tr, bif.sc, bif.err,
                           m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_sc, m_err);
      end
    end
    idle(); rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    idle();
    test_reset();
    test_fetch();
    test_wrap_priority();
    test_mem_write();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mano_bus_datapath.md
# mano_bus_datapath

Register-transfer datapath at the receiving end of the Mano basic-computer common bus. It takes the 3-bit bus select `s` produced by the common-bus select encoder and drives the selected source onto the 16-bit bus. It then loads, increments or clears the destination registers (AR, PC, DR, AC, IR, TR), the 4-bit sequence counter SC and the memory write port on the rising clock edge. It sits between the control unit and the external 4096x16 memory.

## Interface
- No parameters; all widths are fixed by the Mano architecture.
- `clk  in  1  rising-edge clock for all state`
- `rst_n  in  1  synchronous active-low reset; sampled on the rising clk edge`
- `s  in  3  bus select: 0 none (bus=0), 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory`
- `ld_ar, inr_ar, clr_ar  in  1 each  AR load / increment / clear`
- `ld_pc, inr_pc, clr_pc  in  1 each  PC load / increment / clear`
- `ld_dr, inr_dr, clr_dr  in  1 each  DR controls`
- `ld_ac, inr_ac, clr_ac  in  1 each  AC controls`
- `ld_ir  in  1  IR load`
- `ld_tr, inr_tr, clr_tr  in  1 each  TR controls`
- `sc_inr, sc_clr  in  1 each  sequence-counter increment / clear`
- `mem_wr  in  1  write request: M[AR] <- bus`
- `mem_rdata  in  16  asynchronous read data M[AR]`
- `mem_addr  out  12  equals AR`
- `mem_wdata  out  16  equals bus`
- `mem_we  out  1  memory write enable`
- `bus  out  16  current bus value`
- `ar, pc  out  12 each  register contents`
- `dr, ac, ir, tr  out  16 each  register contents`
- `sc  out  4  sequence counter`
- `err  out  1  sticky illegal-operation flag`

## Operation
- **Bus mux (combinational).**
  - s=1 and s=2 drive {4'b0, AR} and {4'b0, PC}.
  - s=3..6 drive the full 16-bit register.
  - s=7 drives mem_rdata.
  - s=0 drives 16'h0000.
- **12-bit registers.** AR and PC load bus[11:0]; the upper bus bits are discarded.
- **Per-register priority.** clr > ld > inr. Only the highest asserted action takes effect.
- **Increment wrap.** AR/PC wrap 12'hFFF -> 12'h000. DR/AC/TR wrap 16'hFFFF -> 16'h0000.
- **Load from own value.** A register may load from the bus while it is the bus source (e.g. s=4 with ld_ac). The result is a no-op hold, which is legal.
- **SC.** sc_clr > sc_inr. Increment wraps 4'hF -> 4'h0. SC holds when neither control is asserted.
- **Memory write.** mem_we = mem_wr & (s != 7), and mem_wdata = bus.
- **Illegal operations.** Any of the following sets `err` on the next edge and holds it until reset:
  - mem_wr with s==7 (memory-to-memory); the write is suppressed.
  - ld_ar with inr_ar in the same cycle; the load wins per priority.
  - ld_pc with inr_pc in the same cycle; the load wins per priority.
  - In every case all other actions in that cycle still execute.
- **Simultaneous writes and AR.** A write to AR and a mem_wr in the same cycle use the *old* AR as the address. The memory write and the AR update happen on the same edge.

## Timing
- The bus, mem_addr, mem_wdata and mem_we outputs are combinational, with zero-cycle latency from s, the registers and mem_rdata.
- All register, SC and err updates take effect on the rising clk edge in which their control is sampled high. The new value is visible one cycle after assertion.
- Reset is synchronous. While rst_n=0 at an edge, all of AR, PC, DR, AC, IR, TR, SC and err become 0 and every control input is ignored.
- Reset asserted mid-sequence (any SC value) returns SC to 0 on that edge.
- bus is 0 after reset when s=0. mem_we is 0 during reset only if mem_wr=0; it is not gated by rst_n.
- No multi-cycle handshakes. The external memory must return mem_rdata combinationally within the same cycle as mem_addr.

## Test plan
- **Reset.** Hold rst_n=0 for 2 edges with random controls -> all registers, SC and err = 0. With s=0, bus=16'h0000.
- **Fetch sequence.**
  - Setup: PC=12'h010, M[010]=16'h7800.
  - T0: s=2, ld_ar -> AR=010.
  - T1: s=7, ld_ir, inr_pc -> IR=7800, PC=011.
  - T2: s=5, ld_ar -> AR=800.
  - Across the three cycles with sc_inr=1, SC steps 0->1->2->3.
- **Wrap and priority.**
  - AC=16'hFFFF with inr_ac -> 16'h0000.
  - PC=12'hFFF with inr_pc -> 12'h000.
  - clr_ac+ld_ac+inr_ac with bus=16'h1234 -> AC=0.
  - SC=15 with sc_inr -> 0.
- **Memory write.** AR=12'h123, AC=16'hBEEF, s=4, mem_wr=1 -> mem_we=1, mem_addr=123, mem_wdata=BEEF. err stays 0.
- **Illegal memory-to-memory.** s=7, mem_wr=1 -> mem_we=0 that cycle. err=1 from the next edge, and it stays 1 until rst_n=0.
- **Reset mid-operation.** At SC=2 with ld_ac and s=3 (DR=16'h00AA), assert rst_n=0 -> on that edge AC=0 (not 00AA) and SC=0.
